button_debouncer: RTL and testbench

Front-end conditioning stage for the board push-buttons (BTN_N, BTN1). It synchronises one raw button input to CLK and filters contact bounce with a slow internal sample tick. It produces a clean level plus single-cycle press and release strobes. Those strobes feed the LED counter logic in `top` as its advance enable, so the counter steps once per press instead of free-running off the divided clock.

---
 rtl/board_pkg.sv | 26 ++
 rtl/button_debouncer_sample_tick.sv | 31 +++
 rtl/button_debouncer.sv | 157 +++++++++++++++
 tb/tb_button_debouncer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/board_pkg.sv
// Shared board-level constants, button FSM state type and a width helper.
// Imported by the button front-end and its tick generator.
package board_pkg;

  localparam int CLK_HZ = 12_000_000;

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_PEND,
    PRESSED,
    RELEASE_PEND
  } btn_state_t;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/button_debouncer_sample_tick.sv
// sample_tick_gen: free-running divider emitting a one-cycle tick.
// Lets slow consumers stay on CLK instead of using a divided clock.
module sample_tick_gen
  import board_pkg::*;
#(
  parameter int TICK_DIV = 12000
) (
  input  logic CLK,
  input  logic RST,
  output logic tick
);

  localparam int DW = (clog2(TICK_DIV) < 1) ? 1 : clog2(TICK_DIV);
  localparam logic [DW-1:0] LAST = DW'(TICK_DIV - 1);

  logic [DW-1:0] div;

  // Count 0..TICK_DIV-1 and wrap on the tick cycle
  always_ff @(posedge CLK) begin
    if (RST) begin
      div <= '0;
    end else if (div == LAST) begin
      div <= '0;
    end else begin
      div <= div + DW'(1);
    end
  end

  assign tick = (div == LAST);

endmodule

// File: rtl/button_debouncer.sv
// Push-button synchroniser, debouncer and press/release strobe source.
// Optional auto-repeat of press_pulse: define DEBOUNCE_AUTOREPEAT_EN.
module button_debouncer
  import board_pkg::*;
#(
  parameter int TICK_DIV       = 12000,
  parameter int STABLE_SAMPLES = 8,
  parameter int ACTIVE_LOW     = 1,
  parameter int REPEAT_DELAY   = 500,
  parameter int REPEAT_RATE    = 100
) (
  input  logic CLK,
  input  logic RST,
  input  logic btn_raw,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int CW = clog2(STABLE_SAMPLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_SAMPLES - 1);
  localparam logic IDLE_RAW = (ACTIVE_LOW != 0);

  logic sync1;
  logic sync2;
  logic s;
  logic tick;

  btn_state_t state;
  btn_state_t state_n;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic press_n;
  logic release_n;

`ifdef DEBOUNCE_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW = (clog2(RMAX + 1) < 1) ? 1 : clog2(RMAX + 1);
  logic [RW-1:0] rpt;
  logic [RW-1:0] rpt_n;
`endif

  sample_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .CLK (CLK),
    .RST (RST),
    .tick(tick)
  );

  // Two-flop synchroniser, reset to the released pad level
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1 <= IDLE_RAW;
      sync2 <= IDLE_RAW;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  assign s = (ACTIVE_LOW != 0) ? ~sync2 : sync2;

  // State, stability count and registered outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= RELEASED;
      cnt           <= '0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      btn_level     <= (state_n == PRESSED) || (state_n == RELEASE_PEND);
      press_pulse   <= press_n;
      release_pulse <= release_n;
    end
  end

`ifdef DEBOUNCE_AUTOREPEAT_EN
  // Held-tick countdown to the next repeat strobe
  always_ff @(posedge CLK) begin
    if (RST) begin
      rpt <= '0;
    end else begin
      rpt <= rpt_n;
    end
  end
`endif

  // Next-state: evaluate one sample per tick against the accepted level
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    press_n   = 1'b0;
    release_n = 1'b0;
`ifdef DEBOUNCE_AUTOREPEAT_EN
    rpt_n     = rpt;
`endif
    if (tick) begin
      unique case (state)
        RELEASED, PRESS_PEND: begin
          if (s) begin
            if (cnt == CNT_LAST) begin
              state_n = PRESSED;
              cnt_n   = '0;
              press_n = 1'b1;
`ifdef DEBOUNCE_AUTOREPEAT_EN
              rpt_n   = RW'(REPEAT_DELAY);
`endif
            end else begin
              state_n = PRESS_PEND;
              cnt_n   = cnt + CW'(1);
            end
          end else begin
            state_n = RELEASED;
            cnt_n   = '0;
          end
        end
        PRESSED, RELEASE_PEND: begin
          if (!s) begin
            if (cnt == CNT_LAST) begin
              state_n   = RELEASED;
              cnt_n     = '0;
              release_n = 1'b1;
`ifdef DEBOUNCE_AUTOREPEAT_EN
              rpt_n     = '0;
`endif
            end else begin
              state_n = RELEASE_PEND;
              cnt_n   = cnt + CW'(1);
            end
          end else begin
            state_n = PRESSED;
            cnt_n   = '0;
`ifdef DEBOUNCE_AUTOREPEAT_EN
            if (state == PRESSED) begin
              if (rpt <= RW'(1)) begin
                press_n = 1'b1;
                rpt_n   = RW'(REPEAT_RATE);
              end else begin
                rpt_n = rpt - RW'(1);
              end
            end
`endif
          end
        end
        default: begin
          state_n = RELEASED;
          cnt_n   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench for button_debouncer: random and directed stimulus.
// A sample-history reference model predicts every strobe and the level.
module tb_button_debouncer;

  localparam int TDIV = 4;
  localparam int NS   = 3;
  localparam int AL   = 1;
  localparam int RD   = 5;
  localparam int RR   = 2;

  typedef struct {
    bit press;
    int cyc;
    bit lvl;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic raw = 1'b1;
  logic lvl;
  logic prs;
  logic rls;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit armed = 1'b0;
  bit m_level = 1'b0;
  ev_t q[$];

  button_debouncer #(
    .TICK_DIV      (TDIV),
    .STABLE_SAMPLES(NS),
    .ACTIVE_LOW    (AL),
    .REPEAT_DELAY  (RD),
    .REPEAT_RATE   (RR)
  ) dut (
    .CLK          (clk),
    .RST          (rst),
    .btn_raw      (raw),
    .btn_level    (lvl),
    .press_pulse  (prs),
    .release_pulse(rls)
  );

  always #5 clk = ~clk;

  // Reference model: pad delayed two edges, one sample every TDIV cycles
  // from reset; a level is accepted after NS consecutive differing samples.
  initial begin
    bit p1, p2, smp, tk;
    int ph, run, held;
    ev_t e;
    p1 = 1'b1; p2 = 1'b1; ph = 0; run = 0; held = 0;
    forever begin
      @(posedge clk);
      cyc++;
      tk  = (ph == TDIV - 1);
      smp = (AL != 0) ? ~p2 : p2;
      if (rst) begin
        armed = 1'b1;
        ph = 0; run = 0; held = 0;
        p1 = (AL != 0); p2 = (AL != 0);
        m_level = 1'b0;
      end else if (armed) begin
        if (tk) begin
          if (smp != m_level) begin
            run++;
            if (run == NS) begin
              m_level = smp;
              run = 0;
              held = 0;
              e.press = smp; e.cyc = cyc; e.lvl = smp;
              q.push_back(e);
            end
          end else begin
`ifdef DEBOUNCE_AUTOREPEAT_EN
            if (m_level && run == 0) begin
              held++;
              if (held == RD || (held > RD && (held - RD) % RR == 0)) begin
                e.press = 1'b1; e.cyc = cyc; e.lvl = 1'b1;
                q.push_back(e);
              end
            end
`endif
            run = 0;
          end
        end
        ph = (ph + 1) % TDIV;
        p2 = p1;
        p1 = raw;
      end
    end
  end

  // Monitor: level every cycle, strobes popped against the scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (armed) begin
        total++;
        if (lvl !== m_level) begin
          bad++;
          $display("FAIL level cyc=%0d act=%b exp=%b", cyc, lvl, m_level);
        end
        while (q.size() > 0 && q[0].cyc < cyc) begin
          total++;
          bad++;
          $display("FAIL missed_strobe cyc=%0d act=none exp_press=%0b",
                   q[0].cyc, q[0].press);
          void'(q.pop_front());
        end
        if (prs === 1'b1 || rls === 1'b1) begin
          total++;
          if (prs === 1'b1 && rls === 1'b1) begin
            bad++;
            $display("FAIL both_strobes cyc=%0d act=11 exp=one", cyc);
          end else if (q.size() == 0 || q[0].cyc != cyc) begin
            bad++;
            $display("FAIL extra_strobe cyc=%0d act=press%b/rel%b exp=none",
                     cyc, prs, rls);
          end else begin
            if (q[0].press != prs || q[0].lvl != lvl) begin
              bad++;
              $display("FAIL strobe_kind cyc=%0d act=p%b l%b exp=p%b l%b",
                       cyc, prs, lvl, q[0].press, q[0].lvl);
            end
            void'(q.pop_front());
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int act,
                         input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic wait_strobe(input bit want_press, input int max,
                             output int lat);
    lat = -1;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if ((want_press ? prs : rls) === 1'b1) begin
        lat = i;
        return;
      end
    end
  endtask

  task automatic count_strobes(input int n, output int np, output int nr);
    np = 0;
    nr = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (prs === 1'b1) np++;
      if (rls === 1'b1) nr++;
    end
  endtask

  initial begin
    int lat, np, nr;

    // Reset held with the button released
    rst = 1'b1;
    raw = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_level", int'(lvl), 0);
    chk("rst_press", int'(prs), 0);
    chk("rst_release", int'(rls), 0);
    rst = 1'b0;
    count_strobes(100, np, nr);
    chk("idle_strobes", np + nr, 0);

    // Clean press then release
    raw = 1'b0;
    wait_strobe(1'b1, 30, lat);
    chk_rng("press_latency", lat, 11, 15);
    chk("press_level", int'(lvl), 1);
    if (lat > 0) repeat (60 - lat) @(negedge clk);
    chk("held_level", int'(lvl), 1);
    raw = 1'b1;
    wait_strobe(1'b0, 30, lat);
    chk_rng("release_latency", lat, 11, 15);
    chk("release_level", int'(lvl), 0);
    repeat (20) @(negedge clk);

    // Bounce shorter than the stability window
    for (int i = 0; i < 16; i++) begin
      raw = (i % 2 == 1);
      count_strobes(5, np, nr);
      chk("bounce_strobes", np + nr, 0);
    end
    raw = 1'b1;
    count_strobes(40, np, nr);
    chk("bounce_tail", np + nr, 0);
    chk("bounce_level", int'(lvl), 0);

    // Reset while a press is pending
    raw = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    count_strobes(11, np, nr);
    chk("pend_rst_quiet", np + nr, 0);
    wait_strobe(1'b1, 4, lat);
    chk("pend_rst_press", int'(lat > 0), 1);
    raw = 1'b1;
    wait_strobe(1'b0, 20, lat);
    chk("pend_rst_release", int'(lat > 0), 1);
    repeat (10) @(negedge clk);

    // Button held through reset
    raw = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wait_strobe(1'b1, 15, lat);
    chk("held_rst_press", int'(lat > 0), 1);
    chk("held_rst_level", int'(lvl), 1);
    raw = 1'b1;
    wait_strobe(1'b0, 20, lat);
    chk("held_rst_release", int'(lat > 0), 1);
    repeat (10) @(negedge clk);

`ifdef DEBOUNCE_AUTOREPEAT_EN
    // Long hold: initial press then repeats at held ticks 5,7,...,59
    raw = 1'b0;
    wait_strobe(1'b1, 20, lat);
    chk("rpt_first", int'(lat > 0), 1);
    count_strobes(240, np, nr);
    chk("rpt_count", np, 28);
    raw = 1'b1;
    wait_strobe(1'b0, 20, lat);
    chk("rpt_release", int'(lat > 0), 1);
    count_strobes(40, np, nr);
    chk("rpt_after_release", np, 0);
`endif

    // Random pad activity with occasional resets
    for (int i = 0; i < 80; i++) begin
      raw = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat ($urandom_range(1, 30)) @(negedge clk);
    end
    raw = 1'b1;
    repeat (60) @(negedge clk);
    chk("queue_drained", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
